// File: rtl/flow_input_scheduler.sv
// Shares the tagged config and pixel input of the multi-flow interpolator between FLUX requesters.
// Each flow latches a config, writes it tagged, then streams ext_size^2 pixels round-robin.
module flow_input_scheduler #(
    parameter int FLUX  = 2,
    parameter int TAG_W = $clog2(FLUX),
    parameter int TAP   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      cfg_valid,
    output logic [FLUX-1:0]      cfg_ready,
    input  logic [3*FLUX-1:0]    cfg_v_alpha,
    input  logic [3*FLUX-1:0]    cfg_h_alpha,
    input  logic [7*FLUX-1:0]    cfg_ext_size,
    input  logic [FLUX-1:0]      pel_valid,
    output logic [FLUX-1:0]      pel_ready,
    input  logic [8*FLUX-1:0]    pel_data,
    output logic [3+TAG_W-1:0]   v_alpha_din,
    output logic [3+TAG_W-1:0]   h_alpha_din,
    output logic [7+TAG_W-1:0]   ext_size_din,
    output logic                 cfg_write,
    input  logic [FLUX-1:0]      cfg_full,
    output logic [8+TAG_W-1:0]   in_pel_din,
    output logic                 in_pel_write,
    input  logic [FLUX-1:0]      in_pel_full,
    output logic [FLUX-1:0]      busy,
    output logic [FLUX-1:0]      done,
    output logic [FLUX-1:0]      err
);

    localparam int unsigned NF      = FLUX;
    localparam logic [6:0]  EXT_MIN = 7'(TAP + 3);
    localparam logic [6:0]  EXT_MAX = 7'(64 + TAP - 1);

    typedef enum logic [1:0] {IDLE, CFG, STREAM} state_e;

    state_e            state_q  [FLUX];
    state_e            state_d  [FLUX];
    logic [2:0]        v_q      [FLUX];
    logic [2:0]        v_d      [FLUX];
    logic [2:0]        h_q      [FLUX];
    logic [2:0]        h_d      [FLUX];
    logic [6:0]        ext_q    [FLUX];
    logic [6:0]        ext_d    [FLUX];
    logic [13:0]       target_q [FLUX];
    logic [13:0]       target_d [FLUX];
    logic [13:0]       count_q  [FLUX];
    logic [13:0]       count_d  [FLUX];
    logic [TAG_W-1:0]  rr_q, rr_d;
    logic [FLUX-1:0]   busy_q, busy_d;
    logic [FLUX-1:0]   done_q, done_d;
    logic [FLUX-1:0]   err_q, err_d;

    logic              cfg_found;
    logic              pel_found;
    logic [6:0]        ext_in;
    int unsigned       idx;

    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        h_d          = h_q;
        ext_d        = ext_q;
        target_d     = target_q;
        count_d      = count_q;
        rr_d         = rr_q;
        busy_d       = '0;
        done_d       = '0;
        err_d        = '0;
        cfg_ready    = '0;
        pel_ready    = '0;
        cfg_write    = 1'b0;
        v_alpha_din  = '0;
        h_alpha_din  = '0;
        ext_size_din = '0;
        in_pel_write = 1'b0;
        in_pel_din   = '0;
        cfg_found    = 1'b0;
        pel_found    = 1'b0;
        ext_in       = '0;
        idx          = 0;

        // Config intake: out-of-range sizes are consumed and flagged, flow stays idle.
        for (int unsigned f = 0; f < NF; f++) begin
            if (state_q[f] == IDLE && cfg_valid[f]) begin
                cfg_ready[f] = 1'b1;
                ext_in       = cfg_ext_size[7*f +: 7];
                if (ext_in >= EXT_MIN && ext_in <= EXT_MAX) begin
                    v_d[f]      = cfg_v_alpha[3*f +: 3];
                    h_d[f]      = cfg_h_alpha[3*f +: 3];
                    ext_d[f]    = ext_in;
                    target_d[f] = 14'(ext_in) * 14'(ext_in);
                    state_d[f]  = CFG;
                end else begin
                    err_d[f] = 1'b1;
                end
            end
        end

        for (int unsigned f = 0; f < NF; f++) begin
            if (!cfg_found && state_q[f] == CFG && !cfg_full[f]) begin
                cfg_found    = 1'b1;
                cfg_write    = 1'b1;
                v_alpha_din  = {TAG_W'(f), v_q[f]};
                h_alpha_din  = {TAG_W'(f), h_q[f]};
                ext_size_din = {TAG_W'(f), ext_q[f]};
                state_d[f]   = STREAM;
                count_d[f]   = '0;
            end
        end

        // Round-robin search begins at rr_q and wraps modulo FLUX.
        for (int unsigned i = 0; i < NF; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NF) idx = idx - NF;
            if (!pel_found && state_q[idx] == STREAM && pel_valid[idx] && !in_pel_full[idx]) begin
                pel_found      = 1'b1;
                pel_ready[idx] = 1'b1;
                in_pel_write   = 1'b1;
                in_pel_din     = {TAG_W'(idx), pel_data[8*idx +: 8]};
                count_d[idx]   = count_q[idx] + 14'd1;
                if (count_q[idx] + 14'd1 == target_q[idx]) begin
                    state_d[idx] = IDLE;
                    done_d[idx]  = 1'b1;
                end
                rr_d = (idx + 1 >= NF) ? '0 : TAG_W'(idx + 1);
            end
        end

        for (int unsigned f = 0; f < NF; f++) begin
            busy_d[f] = (state_d[f] != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned f = 0; f < NF; f++) begin
                state_q[f]  <= IDLE;
                v_q[f]      <= '0;
                h_q[f]      <= '0;
                ext_q[f]    <= '0;
                target_q[f] <= '0;
                count_q[f]  <= '0;
            end
            rr_q   <= '0;
            busy_q <= '0;
            done_q <= '0;
            err_q  <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            h_q      <= h_d;
            ext_q    <= ext_d;
            target_q <= target_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_flow_input_scheduler.sv
// Directed bench for flow_input_scheduler with two flows; a negedge monitor logs writes and pulses.
module tb_flow_input_scheduler;

    localparam int FLUX  = 2;
    localparam int TAG_W = 1;

    logic                clk;
    logic                rst;
    logic [FLUX-1:0]     cfg_valid;
    logic [FLUX-1:0]     cfg_ready;
    logic [3*FLUX-1:0]   cfg_v_alpha;
    logic [3*FLUX-1:0]   cfg_h_alpha;
    logic [7*FLUX-1:0]   cfg_ext_size;
    logic [FLUX-1:0]     pel_valid;
    logic [FLUX-1:0]     pel_ready;
    logic [8*FLUX-1:0]   pel_data;
    logic [3+TAG_W-1:0]  v_alpha_din;
    logic [3+TAG_W-1:0]  h_alpha_din;
    logic [7+TAG_W-1:0]  ext_size_din;
    logic                cfg_write;
    logic [FLUX-1:0]     cfg_full;
    logic [8+TAG_W-1:0]  in_pel_din;
    logic                in_pel_write;
    logic [FLUX-1:0]     in_pel_full;
    logic [FLUX-1:0]     busy;
    logic [FLUX-1:0]     done;
    logic [FLUX-1:0]     err;

    flow_input_scheduler #(.FLUX(FLUX), .TAG_W(TAG_W), .TAP(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_v_alpha(cfg_v_alpha), .cfg_h_alpha(cfg_h_alpha), .cfg_ext_size(cfg_ext_size),
        .pel_valid(pel_valid), .pel_ready(pel_ready), .pel_data(pel_data),
        .v_alpha_din(v_alpha_din), .h_alpha_din(h_alpha_din), .ext_size_din(ext_size_din),
        .cfg_write(cfg_write), .cfg_full(cfg_full),
        .in_pel_din(in_pel_din), .in_pel_write(in_pel_write), .in_pel_full(in_pel_full),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor state, written only by the negedge monitor.
    int cyc = 0;
    int wr_cnt [FLUX] = '{0, 0};
    int done_cnt [FLUX] = '{0, 0};
    int err_cnt [FLUX] = '{0, 0};
    int last_wr_cyc [FLUX] = '{0, 0};
    int done_cyc [FLUX] = '{0, 0};
    int bad_data = 0;
    int bad_rdy = 0;
    int tag_log [$];
    int cfg_tag_q [$];
    int cfg_cyc_q [$];
    int cfg_v_q [$];
    int cfg_h_q [$];
    int cfg_e_q [$];

    logic [7:0] pdata [FLUX];
    initial begin
        pdata[0] = 8'h5A;
        pdata[1] = 8'hC3;
    end

    always @(negedge clk) begin
        int t;
        logic [FLUX-1:0] exp_rdy;
        cyc++;
        exp_rdy = '0;
        if (in_pel_write) begin
            t = int'(in_pel_din[8]);
            wr_cnt[t]++;
            tag_log.push_back(t);
            last_wr_cyc[t] = cyc;
            exp_rdy[t] = 1'b1;
            if (in_pel_din[7:0] != pdata[t]) bad_data++;
        end
        if (pel_ready != exp_rdy) bad_rdy++;
        if (cfg_write) begin
            cfg_tag_q.push_back(int'(v_alpha_din[3]));
            cfg_cyc_q.push_back(cyc);
            cfg_v_q.push_back(int'(v_alpha_din));
            cfg_h_q.push_back(int'(h_alpha_din));
            cfg_e_q.push_back(int'(ext_size_din));
        end
        for (int f = 0; f < FLUX; f++) begin
            if (done[f]) begin
                done_cnt[f]++;
                done_cyc[f] = cyc;
            end
            if (err[f]) err_cnt[f]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cfg_valid = '0;
        cfg_full = '0;
        in_pel_full = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_cfg(input int f, input int v, input int h, input int e);
        cfg_valid[f] = 1'b1;
        cfg_v_alpha[3*f +: 3] = 3'(v);
        cfg_h_alpha[3*f +: 3] = 3'(h);
        cfg_ext_size[7*f +: 7] = 7'(e);
    endtask

    task automatic do_cfg(input int f, input int v, input int h, input int e, input string tag);
        set_cfg(f, v, h, e);
        #1;
        check(tag, int'(cfg_ready[f]), 1);
        tick();
        cfg_valid[f] = 1'b0;
    endtask

    task automatic wait_done(input int f, input int want, input int budget, input string tag);
        int t = 0;
        while (done_cnt[f] < want && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(tag, done_cnt[f], want);
    endtask

    int b_wr0, b_wr1, b_cfg, b_log, b_done0, b_done1, b_err0, b_err1, n1;

    initial begin
        rst = 1'b0;
        cfg_valid = '0;
        cfg_v_alpha = '0;
        cfg_h_alpha = '0;
        cfg_ext_size = '0;
        pel_valid = 2'b11;
        pel_data = {pdata[1], pdata[0]};
        cfg_full = '0;
        in_pel_full = '0;
        #1;
        pel_data = {pdata[1], pdata[0]};
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_pel_write", int'(in_pel_write), 0);
        check("rst_cfg_write", int'(cfg_write), 0);
        check("rst_pel_din", int'(in_pel_din), 0);
        rst = 1'b1;
        tick();

        // Single flow, 15x15 block.
        b_cfg = cfg_tag_q.size(); b_wr0 = wr_cnt[0]; b_wr1 = wr_cnt[1]; b_done0 = done_cnt[0];
        do_cfg(0, 2, 0, 15, "t1_cfg_ready");
        check("t1_busy", int'(busy[0]), 1);
        wait_done(0, b_done0 + 1, 400, "t1_done");
        check("t1_cfg_count", cfg_tag_q.size() - b_cfg, 1);
        check("t1_v_din", cfg_v_q[b_cfg], 2);
        check("t1_h_din", cfg_h_q[b_cfg], 0);
        check("t1_ext_din", cfg_e_q[b_cfg], 15);
        check("t1_pixels", wr_cnt[0] - b_wr0, 225);
        check("t1_no_flow1", wr_cnt[1] - b_wr1, 0);
        check("t1_done_lat", done_cyc[0] - last_wr_cyc[0], 1);
        tick();
        check("t1_done_once", done_cnt[0] - b_done0, 1);
        check("t1_idle", int'(busy[0]), 0);

        // Two flows configured in the same cycle.
        b_cfg = cfg_tag_q.size(); b_log = tag_log.size();
        b_wr0 = wr_cnt[0]; b_wr1 = wr_cnt[1]; b_done0 = done_cnt[0]; b_done1 = done_cnt[1];
        set_cfg(0, 5, 3, 39);
        set_cfg(1, 1, 7, 15);
        #1;
        check("t2_cfg_ready", int'(cfg_ready), 3);
        tick();
        cfg_valid = '0;
        wait_done(1, b_done1 + 1, 1000, "t2_done1");
        wait_done(0, b_done0 + 1, 3000, "t2_done0");
        tick();
        check("t2_cfg_first", cfg_tag_q[b_cfg], 0);
        check("t2_cfg_second", cfg_tag_q[b_cfg + 1], 1);
        check("t2_cfg_b2b", cfg_cyc_q[b_cfg + 1] - cfg_cyc_q[b_cfg], 1);
        check("t2_v0", cfg_v_q[b_cfg], 5);
        check("t2_h0", cfg_h_q[b_cfg], 3);
        check("t2_e0", cfg_e_q[b_cfg], 39);
        check("t2_v1", cfg_v_q[b_cfg + 1], 9);
        check("t2_h1", cfg_h_q[b_cfg + 1], 15);
        check("t2_e1", cfg_e_q[b_cfg + 1], 143);
        for (int i = 0; i < 6; i++) check($sformatf("t2_tag%0d", i), tag_log[b_log + i], i % 2);
        n1 = 0;
        for (int i = b_log + 451; i < tag_log.size(); i++) n1 += tag_log[i];
        check("t2_tail_flow0_only", n1, 0);
        check("t2_pix1", wr_cnt[1] - b_wr1, 225);
        check("t2_pix0", wr_cnt[0] - b_wr0, 1521);
        check("t2_done0_once", done_cnt[0] - b_done0, 1);
        check("t2_done1_once", done_cnt[1] - b_done1, 1);

        // Back-pressure on flow 1 while both stream.
        set_cfg(0, 0, 0, 39);
        set_cfg(1, 0, 0, 39);
        tick();
        cfg_valid = '0;
        repeat (10) tick();
        in_pel_full[1] = 1'b1;
        b_log = tag_log.size();
        #1;
        check("t3_rdy1_low", int'(pel_ready[1]), 0);
        repeat (20) tick();
        in_pel_full[1] = 1'b0;
        tick();
        tick();
        check("t3_held_writes", tag_log.size() - b_log, 22);
        n1 = 0;
        for (int i = 0; i < 20; i++) n1 += tag_log[b_log + i];
        check("t3_only_flow0", n1, 0);
        check("t3_resume_flow1", tag_log[b_log + 20], 1);
        check("t3_then_flow0", tag_log[b_log + 21], 0);
        do_reset();

        // Illegal sizes on both sides of the legal window, then a legal config.
        b_cfg = cfg_tag_q.size(); b_err0 = err_cnt[0]; b_err1 = err_cnt[1];
        do_cfg(0, 1, 1, 5, "t4_rdy_5");
        check("t4_err_pulse", int'(err[0]), 1);
        check("t4_busy0", int'(busy[0]), 0);
        do_cfg(1, 1, 1, 80, "t4_rdy_80");
        check("t4_err1_pulse", int'(err[1]), 1);
        check("t4_busy1", int'(busy[1]), 0);
        do_cfg(0, 1, 1, 10, "t4_rdy_10");
        do_cfg(1, 1, 1, 72, "t4_rdy_72");
        tick();
        check("t4_err_clear", int'(err), 0);
        check("t4_err0_cnt", err_cnt[0] - b_err0, 2);
        check("t4_err1_cnt", err_cnt[1] - b_err1, 2);
        check("t4_no_cfg_write", cfg_tag_q.size() - b_cfg, 0);
        b_wr0 = wr_cnt[0]; b_done0 = done_cnt[0];
        do_cfg(0, 0, 0, 11, "t4_rdy_11");
        wait_done(0, b_done0 + 1, 300, "t4_done_11");
        check("t4_pix_11", wr_cnt[0] - b_wr0, 121);
        tick();
        b_wr0 = wr_cnt[0]; b_done0 = done_cnt[0];
        do_cfg(0, 0, 0, 15, "t4_rdy_15");
        wait_done(0, b_done0 + 1, 400, "t4_done_15");
        check("t4_pix_15", wr_cnt[0] - b_wr0, 225);
        check("t4_err_none", err_cnt[0] - b_err0, 2);

        // Config bus held full.
        do_reset();
        b_cfg = cfg_tag_q.size(); b_wr0 = wr_cnt[0]; b_done0 = done_cnt[0];
        cfg_full[0] = 1'b1;
        do_cfg(0, 3, 4, 15, "t5_rdy");
        repeat (5) tick();
        check("t5_withheld", cfg_tag_q.size() - b_cfg, 0);
        check("t5_no_pix", wr_cnt[0] - b_wr0, 0);
        cfg_full[0] = 1'b0;
        tick();
        check("t5_issued", cfg_tag_q.size() - b_cfg, 1);
        check("t5_no_pix_before", wr_cnt[0] - b_wr0, 0);
        wait_done(0, b_done0 + 1, 400, "t5_done");
        check("t5_pix", wr_cnt[0] - b_wr0, 225);

        // Reset mid-stream abandons the flow.
        tick();
        b_wr0 = wr_cnt[0]; b_done0 = done_cnt[0];
        do_cfg(0, 0, 0, 15, "t6_rdy");
        n1 = 0;
        while (wr_cnt[0] - b_wr0 < 100 && n1 < 300) begin
            tick();
            n1++;
        end
        check("t6_reached_100", (wr_cnt[0] - b_wr0 >= 100) ? 1 : 0, 1);
        rst = 1'b0;
        tick();
        check("t6_busy", int'(busy), 0);
        check("t6_pel_write", int'(in_pel_write), 0);
        check("t6_done", int'(done), 0);
        tick();
        tick();
        rst = 1'b1;
        check("t6_no_done", done_cnt[0] - b_done0, 0);
        tick();
        b_wr0 = wr_cnt[0];
        do_cfg(0, 0, 0, 15, "t6_rdy_again");
        wait_done(0, b_done0 + 1, 400, "t6_done_again");
        check("t6_pix", wr_cnt[0] - b_wr0, 225);

        check("pel_data_tag", bad_data, 0);
        check("pel_ready_match", bad_rdy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
